// File: rtl/rol_pkg.sv
// Shared constants, types and the constant-rotate helper for the rotate-left pipeline.
// The per-stage flag bundle exists only when ROL_FLAGS_EN is defined.
package rol_pkg;

    localparam int ROL_WIDTH  = 32;
    localparam int ROL_SHW    = 5;
    localparam int ROL_STAGES = 5;

    typedef logic [ROL_WIDTH-1:0] rol_word_t;
    typedef logic [ROL_SHW-1:0]   rol_amt_t;

`ifdef ROL_FLAGS_EN
    // carry is only ever set by a stage that actually rotates, so it already
    // reads 0 for a total amount of zero; zero is rotation-invariant.
    typedef struct packed {
        logic carry;
        logic zero;
    } rol_flags_t;
`endif

    function automatic rol_word_t rol_const(input rol_word_t w, input int unsigned sh);
        rol_const = (w << sh) | (w >> (ROL_WIDTH - sh));
    endfunction

endpackage

// File: rtl/rol_stage.sv
// One registered rotate-left-by-2^K stage with valid, hold/advance and async reset.
// Optional flag tracking is compiled in with ROL_FLAGS_EN.
module rol_stage
    import rol_pkg::*;
#(
    parameter int K = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       in_valid,
    input  rol_word_t  in_data,
    input  rol_amt_t   in_rem,
`ifdef ROL_FLAGS_EN
    input  rol_flags_t in_flags,
    output rol_flags_t out_flags,
`endif
    output logic       out_valid,
    output rol_word_t  out_data,
    output rol_amt_t   out_rem
);

    localparam int unsigned SH = 32'd1 << K;

    // in_rem[0] is amount bit K; higher bits ride along for the later stages
    rol_word_t rot_s;
    assign rot_s = in_rem[0] ? rol_const(in_data, SH) : in_data;

    logic      valid_r;
    rol_word_t data_r;
    rol_amt_t  rem_r;

`ifdef ROL_FLAGS_EN
    rol_flags_t flags_r;
    rol_flags_t flags_next_s;
    assign flags_next_s.carry = in_rem[0] ? rot_s[0] : in_flags.carry;
    assign flags_next_s.zero  = in_flags.zero;

    // Flags move with the data and share its advance enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_r <= '{carry: 1'b0, zero: 1'b0};
        end else if (adv) begin
            flags_r <= flags_next_s;
        end
    end

    assign out_flags = flags_r;
`endif

    // Stage register: load on advance, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= {ROL_WIDTH{1'b0}};
            rem_r   <= {ROL_SHW{1'b0}};
        end else if (adv) begin
            valid_r <= in_valid;
            data_r  <= rot_s;
            rem_r   <= in_rem >> 1;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_rem   = rem_r;

endmodule

// File: rtl/rol_32_pipe.sv
// Five-stage pipelined 32-bit rotate-left with valid/ready on both sides.
// Define ROL_FLAGS_EN to add the out_zero/out_carry result flags.
module rol_32_pipe
    import rol_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_num,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ROL_FLAGS_EN
    output logic             out_zero,
    output logic             out_carry,
`endif
    output logic [WIDTH-1:0] out_data
);

    logic [ROL_STAGES:0]   valid_s;
    logic [ROL_STAGES-1:0] adv_s;
    rol_word_t             data_s [ROL_STAGES+1];
    rol_amt_t              rem_s  [ROL_STAGES+1];
    rol_amt_t              rem_unused;

    assign valid_s[0] = in_valid;
    assign data_s[0]  = in_data;
    assign rem_s[0]   = in_num;
    assign rem_unused = rem_s[ROL_STAGES];

`ifdef ROL_FLAGS_EN
    rol_flags_t flags_s [ROL_STAGES+1];
    assign flags_s[0] = '{carry: 1'b0, zero: (in_data == {WIDTH{1'b0}})};
    assign out_zero   = flags_s[ROL_STAGES].zero;
    assign out_carry  = flags_s[ROL_STAGES].carry;
`endif

    // Bubble-collapsing advance chain: a stage moves if the one below is empty or moving
    always_comb begin : adv_chain
        logic go;
        adv_s = {ROL_STAGES{1'b0}};
        go    = out_ready;
        for (int k = ROL_STAGES - 1; k >= 0; k--) begin
            go       = go || !valid_s[k + 1];
            adv_s[k] = go;
        end
    end

    for (genvar k = 0; k < ROL_STAGES; k++) begin : g_stage
        rol_stage #(.K(k)) u_stage (
            .clk       (clk),
            .rst       (rst),
            .adv       (adv_s[k]),
            .in_valid  (valid_s[k]),
            .in_data   (data_s[k]),
            .in_rem    (rem_s[k]),
`ifdef ROL_FLAGS_EN
            .in_flags  (flags_s[k]),
            .out_flags (flags_s[k + 1]),
`endif
            .out_valid (valid_s[k + 1]),
            .out_data  (data_s[k + 1]),
            .out_rem   (rem_s[k + 1])
        );
    end

    assign in_ready  = adv_s[0];
    assign out_valid = valid_s[ROL_STAGES];
    assign out_data  = data_s[ROL_STAGES];

endmodule

// File: tb/tb_rol_32_pipe.sv
// Directed self-checking bench for rol_32_pipe; flag checks compile in with ROL_FLAGS_EN.
module tb_rol_32_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [4:0]  in_num = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
`ifdef ROL_FLAGS_EN
    logic        out_zero;
    logic        out_carry;
`endif

    rol_32_pipe dut (
`ifdef ROL_FLAGS_EN
        .out_zero  (out_zero),
        .out_carry (out_carry),
`endif
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_num    (in_num),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] op_data[$];
    logic [4:0]  op_num[$];
    logic [31:0] got_data[$];
    logic        got_zero[$];
    logic        got_carry[$];
    int          acc_at_stall;
    int          drops;
    int          first_emit;
    int          last_emit;
    logic        rdy_stalled;
    logic        rdy_release;

    // Reference rotate built bit by bit: bit i moves to (i+n) mod 32
    function automatic logic [31:0] model_rol(input logic [31:0] v, input logic [4:0] n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 32; i++) r[(i + int'(n)) % 32] = v[i];
        return r;
    endfunction

    // Feeds op queues, holds out_ready low for `stall` cycles, collects results
    task automatic pump(input int stall, input int min_cycles, input int budget);
        int  idx;
        int  cyc;
        logic acc;
        idx = 0; cyc = 0; drops = 0; first_emit = -1; last_emit = -1;
        acc_at_stall = -1; rdy_stalled = 1'bx; rdy_release = 1'bx;
        got_data.delete(); got_zero.delete(); got_carry.delete();
        @(negedge clk);
        while ((idx < op_data.size() || got_data.size() < op_data.size() || cyc < min_cycles) && cyc < budget) begin
            if (idx < op_data.size()) begin
                in_valid = 1'b1; in_data = op_data[idx]; in_num = op_num[idx];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (cyc >= stall);
            #1;
            if (in_valid && !in_ready) drops++;
            if (cyc == stall - 1) rdy_stalled = in_ready;
            if (cyc == stall) begin rdy_release = in_ready; acc_at_stall = idx; end
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
`ifdef ROL_FLAGS_EN
                got_zero.push_back(out_zero);
                got_carry.push_back(out_carry);
`endif
                if (first_emit < 0) first_emit = cyc;
                last_emit = cyc;
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_data !== 32'h0) begin fails++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
`ifdef ROL_FLAGS_EN
        tests++; if ({out_zero, out_carry} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {out_zero, out_carry}); end
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL reset_release: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
    endtask

    // First accept happens on the first rising edge after reset release; accept edge is cycle 1
    task automatic test_latency();
        int k;
        in_valid = 1'b1; in_data = 32'h8000_0001; in_num = 5'd1; out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL lat_in_ready: got %b want 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin @(posedge clk); @(negedge clk); k++; end
        tests++; if (k !== 4) begin fails++; $display("FAIL lat_cycles: got %0d edges after accept want 4", k); end
        tests++; if (out_data !== 32'h0000_0003) begin fails++; $display("FAIL lat_data: got %h want 00000003", out_data); end
`ifdef ROL_FLAGS_EN
        tests++; if ({out_carry, out_zero} !== 2'b10) begin fails++; $display("FAIL lat_flags: got carry,zero=%b want 10", {out_carry, out_zero}); end
`endif
        @(posedge clk); @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_no_dup: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_vectors();
        logic [31:0] exp_d[4] = '{32'h2345_6781, 32'h1234_5678, 32'h091A_2B3C, 32'h0000_0001};
        logic        exp_c[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        op_data = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0000_0001};
        op_num  = '{5'd4, 5'd0, 5'd31, 5'd0};
        pump(0, 0, 100);
        tests++; if (got_data.size() !== 4) begin fails++; $display("FAIL vec_count: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4; i++) begin
            tests++; if ((i < got_data.size() ? got_data[i] : 32'hxxxx_xxxx) !== exp_d[i]) begin fails++; $display("FAIL vec_data[%0d]: got %h want %h", i, (i < got_data.size() ? got_data[i] : 32'hxxxx_xxxx), exp_d[i]); end
`ifdef ROL_FLAGS_EN
            tests++; if ((i < got_carry.size() ? got_carry[i] : 1'bx) !== exp_c[i]) begin fails++; $display("FAIL vec_carry[%0d]: got %b want %b", i, (i < got_carry.size() ? got_carry[i] : 1'bx), exp_c[i]); end
`else
            if (exp_c[i] === 1'bz) $display("unreachable");
`endif
        end
    endtask

    task automatic test_flags();
        op_data = '{32'h8000_0000, 32'h0000_0000};
        op_num  = '{5'd1, 5'd7};
        pump(0, 0, 100);
        tests++; if (got_data.size() !== 2) begin fails++; $display("FAIL flg_count: got %0d want 2", got_data.size()); end
        tests++; if ((got_data.size() > 0 ? got_data[0] : 32'hxxxx_xxxx) !== 32'h0000_0001) begin fails++; $display("FAIL flg_data0: got %h want 00000001", (got_data.size() > 0 ? got_data[0] : 32'hxxxx_xxxx)); end
        tests++; if ((got_data.size() > 1 ? got_data[1] : 32'hxxxx_xxxx) !== 32'h0000_0000) begin fails++; $display("FAIL flg_data1: got %h want 00000000", (got_data.size() > 1 ? got_data[1] : 32'hxxxx_xxxx)); end
`ifdef ROL_FLAGS_EN
        tests++; if ((got_carry.size() > 1 ? {got_carry[0], got_zero[0], got_carry[1], got_zero[1]} : 4'bxxxx) !== 4'b1001) begin fails++; $display("FAIL flg_bits: got c0,z0,c1,z1=%b want 1001", (got_carry.size() > 1 ? {got_carry[0], got_zero[0], got_carry[1], got_zero[1]} : 4'bxxxx)); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        op_data.delete(); op_num.delete();
        for (int i = 0; i < 32; i++) begin op_data.push_back(32'hDEAD_BEEF); op_num.push_back(5'(i)); end
        pump(0, 0, 200);
        tests++; if (drops !== 0) begin fails++; $display("FAIL b2b_in_ready: got %0d stalled cycles want 0", drops); end
        tests++; if (got_data.size() !== 32) begin fails++; $display("FAIL b2b_count: got %0d want 32", got_data.size()); end
        tests++; if (last_emit - first_emit !== 31) begin fails++; $display("FAIL b2b_gapless: got span %0d want 31", last_emit - first_emit); end
        tests++; if ((got_data.size() > 4 ? got_data[4] : 32'hxxxx_xxxx) !== 32'hEADB_EEFD) begin fails++; $display("FAIL b2b_n4: got %h want eadbeefd", (got_data.size() > 4 ? got_data[4] : 32'hxxxx_xxxx)); end
        for (int i = 0; i < 32; i++) begin
            e = model_rol(32'hDEAD_BEEF, 5'(i));
            tests++; if ((i < got_data.size() ? got_data[i] : 32'hxxxx_xxxx) !== e) begin fails++; $display("FAIL b2b_data[%0d]: got %h want %h", i, (i < got_data.size() ? got_data[i] : 32'hxxxx_xxxx), e); end
`ifdef ROL_FLAGS_EN
            tests++; if ((i < got_carry.size() ? got_carry[i] : 1'bx) !== ((i != 0) ? e[0] : 1'b0)) begin fails++; $display("FAIL b2b_carry[%0d]: got %b want %b", i, (i < got_carry.size() ? got_carry[i] : 1'bx), ((i != 0) ? e[0] : 1'b0)); end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        op_data.delete(); op_num.delete();
        for (int i = 0; i < 8; i++) begin op_data.push_back(32'hA5A5_0000 | 32'(i)); op_num.push_back(5'(i + 1)); end
        pump(12, 0, 200);
        tests++; if (acc_at_stall !== 5) begin fails++; $display("FAIL bp_accepted: got %0d want 5", acc_at_stall); end
        tests++; if (rdy_stalled !== 1'b0) begin fails++; $display("FAIL bp_ready_full: got %b want 0", rdy_stalled); end
        tests++; if (rdy_release !== 1'b1) begin fails++; $display("FAIL bp_ready_release: got %b want 1", rdy_release); end
        tests++; if (got_data.size() !== 8) begin fails++; $display("FAIL bp_count: got %0d want 8", got_data.size()); end
        for (int i = 0; i < 8; i++) begin
            e = model_rol(32'hA5A5_0000 | 32'(i), 5'(i + 1));
            tests++; if ((i < got_data.size() ? got_data[i] : 32'hxxxx_xxxx) !== e) begin fails++; $display("FAIL bp_data[%0d]: got %h want %h", i, (i < got_data.size() ? got_data[i] : 32'hxxxx_xxxx), e); end
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 32'h0F0F_0000 | 32'(i); in_num = 5'd3;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_loaded: got out_valid %b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_async_clear: got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        @(negedge clk);
        rst = 1'b0;
        op_data.delete(); op_num.delete();
        pump(0, 10, 20);
        tests++; if (got_data.size() !== 0) begin fails++; $display("FAIL mid_stale: got %0d results want 0", got_data.size()); end
        op_data = '{32'h1234_5678};
        op_num  = '{5'd8};
        pump(0, 0, 50);
        tests++; if ((got_data.size() == 1 ? got_data[0] : 32'hxxxx_xxxx) !== 32'h3456_7812) begin fails++; $display("FAIL mid_next_op: got %h (n=%0d) want 34567812", (got_data.size() > 0 ? got_data[0] : 32'hxxxx_xxxx), got_data.size()); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_vectors();
        test_flags();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
